// File: rtl/sramlike_mem_responder.sv
// Slave end of the sram-like bus: one outstanding request, word RAM,
// programmable accept throttling and response latency.
module sramlike_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int ADDR_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] AD  = 4'(ADDR_DELAY);
  localparam logic [3:0] LM1 = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  dcnt;
  logic [3:0]  lcnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be;
  logic        accept;
  logic        unused_hi;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_in;

  assign idx       = addr_q[ADDR_WIDTH+1:2];
  assign idx_in    = addr[ADDR_WIDTH+1:2];
  assign unused_hi = ^addr_q[31:ADDR_WIDTH+2];

  assign addr_ok = (state == IDLE) && (dcnt == AD);
  assign accept  = req && addr_ok;

  // Misaligned or illegal sizes leave be at 0 so the RAM is untouched.
  always_comb begin
    be = 4'b0000;
    unique case (size_q)
      2'd0: be = 4'b0001 << addr_q[1:0];
      2'd1: if (!addr_q[0]) be = 4'b0011 << addr_q[1:0];
      2'd2: if (addr_q[1:0] == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dcnt    <= 4'd0;
      lcnt    <= 4'd0;
      data_ok <= 1'b0;
      rdata   <= 32'h0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      data_ok <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            lcnt    <= 4'd1;
            dcnt    <= 4'd0;
            if (LATENCY == 1) begin
              state   <= RESP;
              data_ok <= 1'b1;
              if (!wr) rdata <= mem[idx_in];
            end else begin
              state <= BUSY;
            end
          end else if (!req) begin
            dcnt <= 4'd0;
          end else if (dcnt < AD) begin
            dcnt <= dcnt + 4'd1;
          end
        end
        BUSY: begin
          lcnt <= lcnt + 4'd1;
          if (lcnt == LM1) begin
            state   <= RESP;
            data_ok <= 1'b1;
            if (!wr_q) rdata <= mem[idx];
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes land on the edge that closes the response cycle.
  always_ff @(posedge clk) begin
    if (state == RESP && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Directed bench: default instance (LATENCY=2, ADDR_DELAY=0) and a
// throttled instance (LATENCY=1, ADDR_DELAY=3).
module tb_sramlike_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        addr_ok, data_ok;

  logic        req1, wr1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata1;
  logic        addr_ok1, data_ok1;

  int vec  = 0;
  int errs = 0;
  int lat;
  bit seen;

  always #5 clk = ~clk;

  sramlike_mem_responder #(.ADDR_WIDTH(12), .LATENCY(2), .ADDR_DELAY(0)) u0 (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .addr_ok(addr_ok), .data_ok(data_ok)
  );

  sramlike_mem_responder #(.ADDR_WIDTH(12), .LATENCY(1), .ADDR_DELAY(3)) u1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1),
    .addr_ok(addr_ok1), .data_ok(data_ok1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns in the data_ok cycle; lat counts cycles after acceptance.
  task automatic txn(input logic w, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     output int l);
    int n;
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    n = 0;
    while (!addr_ok && n < 20) begin tick(); n++; end
    tick();
    req = 1'b0; wr = ~w; size = 2'd2;
    addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A;
    l = 1;
    while (!data_ok && l < 20) begin tick(); l++; end
  endtask

  task automatic txn1(input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    int n;
    req1 = 1'b1; wr1 = w; size1 = 2'd2; addr1 = a; wdata1 = d;
    n = 0;
    while (!addr_ok1 && n < 20) begin tick(); n++; end
    tick();
    req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req = 0; wr = 0; size = 0; addr = 0; wdata = 0;
    req1 = 0; wr1 = 0; size1 = 0; addr1 = 0; wdata1 = 0;
    tick(); tick();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_data_ok", {31'b0, data_ok}, 32'h0);
    chk("reset_addr_ok", {31'b0, addr_ok}, 32'h1);
    rst = 1'b1;
    tick();

    txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, lat);
    chk("wr_word_lat", 32'(lat), 32'd2);
    chk("wr_rdata_kept", rdata, 32'h0);
    tick();
    chk("strobe_one_cycle", {31'b0, data_ok}, 32'h0);
    txn(1'b0, 2'd2, 32'h10, 32'h0, lat);
    chk("rd_word_lat", 32'(lat), 32'd2);
    chk("rd_word", rdata, 32'hDEADBEEF);

    // Reset in the middle of a read.
    tick();
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
    tick();
    req = 1'b0;
    chk("busy_no_addr_ok", {31'b0, addr_ok}, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_addr_ok", {31'b0, addr_ok}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (data_ok) seen = 1'b1;
      tick();
    end
    chk("dropped_no_data_ok", {31'b0, seen}, 32'h0);
    txn(1'b0, 2'd2, 32'h10, 32'h0, lat);
    chk("ram_survives_rst", rdata, 32'hDEADBEEF);

    // Byte and halfword lanes.
    txn(1'b1, 2'd2, 32'h20, 32'h11223344, lat);
    txn(1'b1, 2'd0, 32'h22, 32'h00AA0000, lat);
    chk("wr_byte_lat", 32'(lat), 32'd2);
    txn(1'b1, 2'd1, 32'h20, 32'h0000BBCC, lat);
    txn(1'b0, 2'd2, 32'h20, 32'h0, lat);
    chk("rd_lanes", rdata, 32'h11AABBCC);

    // Misaligned and illegal size complete without touching RAM.
    txn(1'b1, 2'd1, 32'h21, 32'hFFFFFFFF, lat);
    chk("misalign_lat", 32'(lat), 32'd2);
    chk("misalign_rdata_kept", rdata, 32'h11AABBCC);
    txn(1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, lat);
    chk("size3_lat", 32'(lat), 32'd2);
    txn(1'b1, 2'd2, 32'h22, 32'hFFFFFFFF, lat);
    txn(1'b0, 2'd2, 32'h20, 32'h0, lat);
    chk("rd_after_bad", rdata, 32'h11AABBCC);

    // Back-to-back with req held, plus index aliasing.
    txn(1'b1, 2'd2, 32'h0, 32'hCAFEF00D, lat);
    tick();
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0;
    tick();
    addr = 32'h4000;
    lat = 1;
    while (!data_ok && lat < 20) begin tick(); lat++; end
    chk("b2b_first_lat", 32'(lat), 32'd2);
    chk("b2b_first", rdata, 32'hCAFEF00D);
    chk("resp_no_addr_ok", {31'b0, addr_ok}, 32'h0);
    tick();
    chk("idle_addr_ok", {31'b0, addr_ok}, 32'h1);
    chk("idle_no_data_ok", {31'b0, data_ok}, 32'h0);
    tick();
    req = 1'b0;
    chk("b2b_busy", {31'b0, data_ok}, 32'h0);
    tick();
    chk("b2b_second_ok", {31'b0, data_ok}, 32'h1);
    chk("alias_rdata", rdata, 32'hCAFEF00D);

    // Throttled instance: interrupted req restarts the delay count.
    req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2;
    addr1 = 32'h8; wdata1 = 32'h12345678;
    chk("thr_c1", {31'b0, addr_ok1}, 32'h0);
    tick();
    chk("thr_c2", {31'b0, addr_ok1}, 32'h0);
    tick();
    req1 = 1'b0;
    chk("thr_drop", {31'b0, addr_ok1}, 32'h0);
    tick();
    req1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("thr_r%0d", i), {31'b0, addr_ok1},
          (i == 4) ? 32'h1 : 32'h0);
      if (i < 4) tick();
    end
    tick();
    req1 = 1'b0;
    chk("thr_wr_lat1", {31'b0, data_ok1}, 32'h1);
    tick();
    chk("thr_strobe", {31'b0, data_ok1}, 32'h0);
    txn1(1'b0, 32'h8, 32'h0);
    chk("thr_rd_lat1", {31'b0, data_ok1}, 32'h1);
    chk("thr_rd", rdata1, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
